int_pulser: RTL and testbench
=============================

Name: int_pulser

Overview:
- Clocked interrupt stage directly downstream of the board's interrupt sources (w5300_int_n, sl811_intrq) and the ports-block enable bits.
- Replaces the purely combinational level path to the ZX-bus with synchronised, latched pending bits and a timed INT pulse.
- The pulse has a fixed length followed by a re-arm holdoff, so the Z80 sees one well-formed INT per event.
- The top level keeps the open-drain driver: zint_n = zint_oe ? 0 : Z.

Parameters:
- PULSE_LEN, 32, INT low time in clk cycles (must be >=1).
- HOLDOFF, 256, minimum clk cycles between the end of one pulse and the start of the next (must be >=1).
- SYNC_STAGES, 2, synchroniser depth for the asynchronous request inputs (must be >=2).

Ports:
- clk  in  1  system clock; the block's only clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- w5300_int_n  in  1  W5300 interrupt, active low, asynchronous.
- sl811_intrq  in  1  SL811 interrupt, active high, asynchronous.
- ena_w5300_int  in  1  enable for pending bit 0.
- ena_sl811_int  in  1  enable for pending bit 1.
- ena_zxbus_int  in  1  allows a pulse to start.
- clr_stb  in  1  one-cycle clear strobe, already in the clk domain.
- clr_mask  in  2  selects which pending bits clr_stb clears (bit0 = w5300, bit1 = sl811).
- pending  out  2  latched pending bits, readable through the ports block.
- internal_int  out  1  OR of the pending bits.
- zint_oe  out  1  1 = drive zint_n low.
- busy  out  1  1 while in the PULSE or HOLDOFF state.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pending=0, zint_oe=0, busy=0, state=IDLE, counter=0.
  - Synchroniser flops load their inactive values: 1 for the w5300 chain, 0 for the sl811 chain.
  - Reset asserted mid-pulse releases zint_oe on the next edge.
- Synchronisation: each request passes through SYNC_STAGES flops. req[0] = ~w5300_int_n after sync; req[1] = sl811_intrq after sync.
- Edge detect: rise[i] = req[i] & ~req_d[i], where req_d is one more flop.
- Pending update, each cycle:
  - Set condition: rise[i] & ena[i].
  - Clear condition: clr_stb & clr_mask[i].
  - Set and clear in the same cycle: set wins.
  - Dropping ena[i] does not clear an existing pending[i].
- Latency: an input transition sets pending SYNC_STAGES+1 cycles later.
- internal_int = |pending. It is a registered-bit OR and combinational from pending only.
- FSM:
  - IDLE:
    - If internal_int & ena_zxbus_int: go to PULSE, cnt = PULSE_LEN-1, zint_oe=1 from the next cycle.
    - Otherwise stay in IDLE.
  - PULSE:
    - zint_oe=1.
    - If cnt==0 or ena_zxbus_int==0: go to HOLDOFF, cnt = HOLDOFF-1, zint_oe=0.
    - Otherwise cnt--.
    - The pulse lasts exactly PULSE_LEN cycles unless aborted.
  - HOLDOFF:
    - zint_oe=0.
    - If cnt==0: go to IDLE; otherwise cnt--.
    - A request still pending when IDLE is re-entered re-triggers a pulse on the following edge.
- Counter width = clog2(max(PULSE_LEN, HOLDOFF)). No wrap: the counter is only decremented when non-zero.
- Clearing pending during PULSE does not shorten the pulse.
- busy = (state != IDLE).

Optional Feature:
- Macro: INT_PULSER_LEVEL_EN.
- When defined:
  - pending[i] = req[i] & ena[i], registered every cycle; clr_stb and clr_mask are ignored.
  - The source must be serviced to drop its request.
  - The FSM is unchanged.
- When undefined: edge-latched behaviour as described under Behaviour.

Decomposition:
- Package int_pulser_pkg holds:
  - the state encoding (IDLE, PULSE, HOLDOFF, 2 bits);
  - default parameter constants;
  - the pending bit index constants (PEND_W5300=0, PEND_SL811=1).
- One sub-module, int_sync:
  - parameterised SYNC_STAGES and reset value;
  - outputs the synchronised level and the rise pulse;
  - instantiated twice.

Test Plan:
1. Reset: hold rst_n=0 for 3 clk with sl811_intrq=1 -> pending=00, zint_oe=0, busy=0 throughout.
2. Single event: ena_sl811_int=1, ena_zxbus_int=1, raise sl811_intrq at cycle 0 ->
   - pending=10 at cycle 3;
   - zint_oe=1 for exactly 32 cycles starting at cycle 4;
   - busy stays 1 for a further 256 cycles;
   - with clr_stb and clr_mask=10 applied during the pulse, no second pulse follows.
3. Re-trigger: same as scenario 2 but never clear -> a second 32-cycle pulse starts 257 cycles after the first pulse ends.
4. Set/clear collision: w5300_int_n falls so that rise[0] coincides with clr_stb and clr_mask=01 -> pending[0]=1 after that edge.
5. Abort: drop ena_zxbus_int at pulse cycle 10 -> zint_oe=0 on the next edge, FSM enters HOLDOFF, and pending is unchanged.
6. Reset mid-pulse: rst_n=0 at pulse cycle 5 -> zint_oe=0 and state=IDLE after that edge. With INT_PULSER_LEVEL_EN defined, pending tracks the request level and clr_stb has no effect.

Source files
------------

// File: rtl/int_pulser_pkg.sv
// Shared types and constants for the int_pulser interrupt stage.
package int_pulser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam int DEF_PULSE_LEN   = 32;
  localparam int DEF_HOLDOFF     = 256;
  localparam int DEF_SYNC_STAGES = 2;

  localparam int NUM_SRC    = 2;
  localparam int PEND_W5300 = 0;
  localparam int PEND_SL811 = 1;

  // Down-counter width sized for the longer of the two phases, never below 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/int_sync.sv
// Request synchroniser: SYNC_STAGES flops, then an active-high level and its rise pulse.
// RST_VAL is the inactive raw level; a source with RST_VAL=1 is treated as active low.
module int_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic req,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_prev_q, req_prev_d;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], async_in};
    req        = sync_q[SYNC_STAGES-1] ^ RST_VAL;
    req_prev_d = req;
    rise       = req & ~req_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= {SYNC_STAGES{RST_VAL}};
      req_prev_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      req_prev_q <= req_prev_d;
    end
  end

endmodule

// File: rtl/int_pulser.sv
// Latched interrupt pending bits driving a fixed-length INT pulse with re-arm holdoff.
// Define INT_PULSER_LEVEL_EN for level-following pending bits (clear strobe ignored).
module int_pulser
  import int_pulser_pkg::*;
#(
  parameter int PULSE_LEN   = DEF_PULSE_LEN,
  parameter int HOLDOFF     = DEF_HOLDOFF,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w5300_int_n,
  input  logic               sl811_intrq,
  input  logic               ena_w5300_int,
  input  logic               ena_sl811_int,
  input  logic               ena_zxbus_int,
  input  logic               clr_stb,
  input  logic [NUM_SRC-1:0] clr_mask,
  output logic [NUM_SRC-1:0] pending,
  output logic               internal_int,
  output logic               zint_oe,
  output logic               busy
);

  localparam int CNT_W = cnt_width(PULSE_LEN, HOLDOFF);

  logic [NUM_SRC-1:0] req, rise, ena;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zint_oe_q, zint_oe_d;

  int_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_w5300 (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (w5300_int_n),
    .req      (req[PEND_W5300]),
    .rise     (rise[PEND_W5300])
  );

  int_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sl811 (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sl811_intrq),
    .req      (req[PEND_SL811]),
    .rise     (rise[PEND_SL811])
  );

  always_comb begin
    ena             = '0;
    ena[PEND_W5300] = ena_w5300_int;
    ena[PEND_SL811] = ena_sl811_int;
  end

`ifdef INT_PULSER_LEVEL_EN
  logic unused_level;
  assign unused_level = ^{clr_stb, clr_mask, rise};

  always_comb begin
    pending_d = req & ena;
  end
`else
  logic unused_edge;
  assign unused_edge = ^req;

  // Set is OR'd in after the clear so a coincident edge survives the strobe.
  always_comb begin
    pending_d = (rise & ena) | (pending_q & ~({NUM_SRC{clr_stb}} & clr_mask));
  end
`endif

  assign pending      = pending_q;
  assign internal_int = |pending_q;
  assign zint_oe      = zint_oe_q;
  assign busy         = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    zint_oe_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (internal_int && ena_zxbus_int) begin
          state_d   = ST_PULSE;
          cnt_d     = CNT_W'(PULSE_LEN - 1);
          zint_oe_d = 1'b1;
        end
      end
      ST_PULSE: begin
        if ((cnt_q == '0) || !ena_zxbus_int) begin
          state_d = ST_HOLDOFF;
          cnt_d   = CNT_W'(HOLDOFF - 1);
        end else begin
          cnt_d     = cnt_q - CNT_W'(1);
          zint_oe_d = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      zint_oe_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      zint_oe_q <= zint_oe_d;
    end
  end

endmodule

// File: tb/tb_int_pulser.sv
// Scoreboard bench for int_pulser: timestamp-based reference model, per-cycle output check.
module tb_int_pulser;

  localparam int PULSE_LEN   = 32;
  localparam int HOLDOFF     = 256;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n, w5300_int_n, sl811_intrq;
  logic       ena_w5300_int, ena_sl811_int, ena_zxbus_int;
  logic       clr_stb;
  logic [1:0] clr_mask;
  logic [1:0] pending;
  logic       internal_int, zint_oe, busy;

  int_pulser #(.PULSE_LEN(PULSE_LEN), .HOLDOFF(HOLDOFF), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .w5300_int_n   (w5300_int_n),
    .sl811_intrq   (sl811_intrq),
    .ena_w5300_int (ena_w5300_int),
    .ena_sl811_int (ena_sl811_int),
    .ena_zxbus_int (ena_zxbus_int),
    .clr_stb       (clr_stb),
    .clr_mask      (clr_mask),
    .pending       (pending),
    .internal_int  (internal_int),
    .zint_oe       (zint_oe),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] pend;
    logic       iint;
    logic       oe;
    logic       busy;
  } exp_t;

  exp_t     exp_q[$];
  bit [1:0] hist[$];   // sampled active-high requests, newest first
  bit [1:0] m_pend;
  int       cyc = 0;
  int       oe_end = 0;    // first edge at which zint_oe is low again
  int       idle_at = 0;   // edge after which the FSM is idle
  int       vectors = 0;
  int       miscompares = 0;

  // Reference model: pulse timing as absolute edge timestamps.
  always @(posedge clk) begin : model
    bit [1:0] req, req_prev, en, clr;
    cyc++;
    if (!rst_n) begin
      m_pend  = '0;
      oe_end  = cyc;
      idle_at = cyc;
      hist.delete();
      for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back(2'b00);
    end else begin
      req      = hist[SYNC_STAGES-1];
      req_prev = hist[SYNC_STAGES];
      en       = {ena_sl811_int, ena_w5300_int};
      clr      = clr_stb ? clr_mask : 2'b00;
      if (cyc - 1 >= idle_at) begin
        if ((m_pend != 0) && ena_zxbus_int) begin
          oe_end  = cyc + PULSE_LEN;
          idle_at = oe_end + HOLDOFF;
        end
      end else if (cyc <= oe_end && !ena_zxbus_int) begin
        oe_end  = cyc;
        idle_at = cyc + HOLDOFF;
      end
`ifdef INT_PULSER_LEVEL_EN
      m_pend = req & en;
`else
      m_pend = ((req & ~req_prev) & en) | (m_pend & ~clr);
`endif
      hist.push_front({sl811_intrq, ~w5300_int_n});
      void'(hist.pop_back());
    end
    exp_q.push_back('{pend: m_pend, iint: (m_pend != 0), oe: (cyc < oe_end), busy: (cyc < idle_at)});
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({pending, internal_int, zint_oe, busy} !== e) begin
        miscompares++;
        $display("FAIL outputs@edge%0d: got pend=%b iint=%b oe=%b busy=%b, want pend=%b iint=%b oe=%b busy=%b",
                 cyc, pending, internal_int, zint_oe, busy, e.pend, e.iint, e.oe, e.busy);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_all();
    clr_stb = 1'b1; clr_mask = 2'b11;
    cycles(1);
    clr_stb = 1'b0; clr_mask = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; w5300_int_n = 1'b1; sl811_intrq = 1'b1;
    ena_w5300_int = 1'b0; ena_sl811_int = 1'b0; ena_zxbus_int = 1'b0;
    clr_stb = 1'b0; clr_mask = 2'b00;
    cycles(3);
    rst_n = 1'b1; sl811_intrq = 1'b0;
    cycles(4);

    // single event, cleared during the pulse
    ena_sl811_int = 1'b1; ena_zxbus_int = 1'b1;
    sl811_intrq = 1'b1;
    cycles(14);
    clr_stb = 1'b1; clr_mask = 2'b10;
    cycles(1);
    clr_stb = 1'b0; clr_mask = 2'b00;
    cycles(320);
    sl811_intrq = 1'b0;
    cycles(5);

    // re-trigger while never cleared
    sl811_intrq = 1'b1;
    cycles(700);
    sl811_intrq = 1'b0;
    clear_all();
    cycles(300);

    // rise on w5300 coincides with a clear of that bit
    ena_w5300_int = 1'b1; ena_zxbus_int = 1'b0;
    w5300_int_n = 1'b0;
    cycles(2);
    clr_stb = 1'b1; clr_mask = 2'b01;
    cycles(1);
    clr_stb = 1'b0; clr_mask = 2'b00;
    cycles(3);
    w5300_int_n = 1'b1;
    clear_all();
    cycles(3);

    // abort at pulse cycle 10
    ena_zxbus_int = 1'b1;
    sl811_intrq = 1'b1;
    cycles(14);
    ena_zxbus_int = 1'b0;
    cycles(3);
    ena_zxbus_int = 1'b1;
    cycles(300);
    sl811_intrq = 1'b0;
    clear_all();
    cycles(300);

    // reset at pulse cycle 5
    w5300_int_n = 1'b0;
    cycles(9);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    w5300_int_n = 1'b1;
    cycles(10);

    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 15) == 0) w5300_int_n = ~w5300_int_n;
      if ($urandom_range(0, 15) == 0) sl811_intrq = ~sl811_intrq;
      if ($urandom_range(0, 63) == 0) ena_w5300_int = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) ena_sl811_int = ($urandom_range(0, 3) != 0);
      if (ena_zxbus_int) ena_zxbus_int = ($urandom_range(0, 199) != 0);
      else               ena_zxbus_int = ($urandom_range(0, 7) == 0);
      clr_stb  = ($urandom_range(0, 7) == 0);
      clr_mask = 2'($urandom_range(0, 3));
      rst_n    = ($urandom_range(0, 2999) != 0);
      cycles(1);
    end

    rst_n = 1'b1; clr_stb = 1'b0;
    cycles(2);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
